cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
Bitstream loader that drives the serial configuration shift chain formed by daisy-chained LE interconnect and routing blocks. It accepts configuration words from a host over a valid/ready stream and serializes them MSB-first into the chain head. It holds config_en high only while bits are being shifted, then checks a CRC-8 trailer word and reports done or error. One instance sits per fabric tile column, between the host config port and the first chain element.

Parameters:
CHAIN_LEN, 48, total configuration bits in the chain (legal range 1..65535)
WORD_W, 8, host word width in bits (must be at least 8)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
en  in  1  global enable; while low, the FSM and counters freeze
start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE
abort  in  1  cancel the current load
word_in  in  WORD_W  host config word
word_valid  in  1  word_in is valid
word_ready  out  1  loader accepts a word this cycle
config_en  out  1  chain shift enable; drives config_en of every chain element
config_data_out  out  1  serial bit into the chain head
busy  out  1  load in progress
done  out  1  load finished (level)
error  out  1  CRC mismatch or abort (level, valid together with done)
bit_count  out  16  bits shifted so far in the current load

Behaviour:
- Reset: FSM=IDLE; all outputs 0; shift register, CRC and counters cleared. Reset mid-load abandons the load immediately. The chain contents are then undefined and a full reload is required.
- States: IDLE, FETCH, SHIFT, CHECK, DONE.
- IDLE/DONE: on start=1 with en=1, clear bit_count, CRC, done and error, then go to FETCH. start while busy is ignored.
- FETCH: word_ready=1. On word_valid && word_ready, load word_in into the shift register, set word_bits=WORD_W and go to SHIFT. No bit is shifted in the accept cycle. The first config_en cycle is the next cycle.
- SHIFT: each cycle, config_en=1 and config_data_out=shreg[MSB].
  - Shift the register left and update the CRC with that bit.
  - Increment bit_count and decrement word_bits.
  - After the shift where bit_count reaches CHAIN_LEN, go to CHECK. Any remaining bits of a partial last word are discarded.
  - Otherwise, after the shift where word_bits reaches 0, go to FETCH.
- Words required: ceil(CHAIN_LEN/WORD_W) data words, plus one CRC word.
- CHECK: word_ready=1. On handshake, compare word_in[7:0] with the CRC, then go to DONE. Upper bits of the CRC word are ignored. Set error=1 on mismatch.
- DONE: done=1; error holds. Both outputs stay until the next start or reset.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. Computed over the shifted bits in shift order. Per-bit update: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).
- config_en is 0 in every state except SHIFT. config_data_out is 0 whenever config_en=0.
- busy=1 in FETCH, SHIFT and CHECK.
- en=0: state, counters, shreg and CRC all hold. config_en=0 and word_ready=0. The host must not expect a handshake; word_valid may be held.
- abort=1 in FETCH, SHIFT or CHECK: the next state is DONE with error=1. config_en is deasserted the same cycle, and a word offered in that cycle is not accepted. abort has priority over the handshake and the shift. abort in IDLE or DONE is ignored.
- Host back-pressure: word_valid may drop at any time in FETCH. The loader waits with config_en=0, and bit_count does not advance.
- bit_count saturates at CHAIN_LEN.

Test Plan:
- CHAIN_LEN=48, WORD_W=8, start, 6 words 0x00, CRC word 0x00 -> config_en high exactly 48 cycles, in runs of 8; done=1, error=0, bit_count=48; config_data_out always 0.
- Same setup, data word0=0x80 and the rest 0x00 -> first shifted bit is 1; a CRC word equal to the model CRC gives error=0; model CRC XOR 0x01 gives done=1, error=1.
- CHAIN_LEN=12, WORD_W=8, words 0xA5 then 0xF0, then the model CRC -> serial sequence 1010_0101_1111 with exactly 12 config_en cycles; low nibble 0000 of the second word is never shifted; done=1, error=0.
- Mid-SHIFT, drop en for 5 cycles, and separately deassert word_valid for 3 cycles in FETCH -> config_en=0 and bit_count frozen in both gaps; the final bit order is identical to the no-stall run.
- abort asserted at bit_count=20 -> config_en=0 the same cycle, done=1, error=1, busy=0; a new start then completes a clean 48-bit load with error=0.
- nrst pulsed low at bit_count=30 -> all outputs 0 asynchronously, FSM=IDLE; start is required before any word_ready.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain loader: accepts host words over valid/ready,
// shifts them MSB-first into the fabric config chain, then checks a CRC-8 trailer.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_en,
  output logic              config_data_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       bit_count
);

  localparam int              WB_W     = $clog2(WORD_W + 1);
  localparam logic [15:0]     LEN_LAST = 16'(CHAIN_LEN - 1);
  localparam logic [15:0]     LEN_MAX  = 16'(CHAIN_LEN);
  localparam logic [WB_W-1:0] WB_FULL  = WB_W'(WORD_W);
  localparam logic [WB_W-1:0] WB_ONE   = WB_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic [7:0]        r_crc;
  logic [WB_W-1:0]   r_word_bits;
  logic [15:0]       r_bit_count;
  logic              r_error;

  logic w_clear;
  logic w_load;
  logic w_shift;
  logic w_check;
  logic w_abort;
  logic w_word_ready;
  logic w_config_en;

  // CRC-8, polynomial 0x07, one serial bit per call
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/shift strobes; abort outranks handshake and shift
  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_check      = 1'b0;
    w_abort      = 1'b0;
    w_word_ready = 1'b0;
    w_config_en  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (en && start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_FETCH: begin
        if (!en) begin
          w_state_nxt = r_state;
        end else if (abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_word_ready = 1'b1;
          if (word_valid) begin
            w_load      = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
      S_SHIFT: begin
        if (!en) begin
          w_state_nxt = r_state;
        end else if (abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_config_en = 1'b1;
          w_shift     = 1'b1;
          // Chain-full wins over end-of-word: leftover bits of a partial word are dropped
          if (r_bit_count == LEN_LAST) begin
            w_state_nxt = S_CHECK;
          end else if (r_word_bits == WB_ONE) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
      S_CHECK: begin
        if (!en) begin
          w_state_nxt = r_state;
        end else if (abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_word_ready = 1'b1;
          if (word_valid) begin
            w_check     = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift register, CRC, bit counters and error flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_shreg     <= '0;
      r_crc       <= 8'h00;
      r_word_bits <= '0;
      r_bit_count <= 16'd0;
      r_error     <= 1'b0;
    end else if (w_clear) begin
      r_shreg     <= '0;
      r_crc       <= 8'h00;
      r_word_bits <= '0;
      r_bit_count <= 16'd0;
      r_error     <= 1'b0;
    end else if (w_abort) begin
      r_error <= 1'b1;
    end else if (w_load) begin
      r_shreg     <= word_in;
      r_word_bits <= WB_FULL;
    end else if (w_shift) begin
      r_shreg     <= {r_shreg[WORD_W-2:0], 1'b0};
      r_crc       <= crc8_step(r_crc, r_shreg[WORD_W-1]);
      r_word_bits <= r_word_bits - WB_ONE;
      if (r_bit_count != LEN_MAX) begin
        r_bit_count <= r_bit_count + 16'd1;
      end else begin
        r_bit_count <= r_bit_count;
      end
    end else if (w_check) begin
      r_error <= (word_in[7:0] != r_crc);
    end else begin
      r_error <= r_error;
    end
  end

  assign word_ready      = w_word_ready;
  assign config_en       = w_config_en;
  assign config_data_out = w_config_en & r_shreg[WORD_W-1];
  assign busy            = (r_state == S_FETCH) || (r_state == S_SHIFT) || (r_state == S_CHECK);
  assign done            = (r_state == S_DONE);
  assign error           = r_error;
  assign bit_count       = r_bit_count;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: two instances (48-bit and 12-bit chains) checked
// against a bit-list/CRC reference model, directed table plus random loads.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst, en, start_a, start_b, abort, word_valid;
  logic [7:0] word_in;

  logic        wr_a, ce_a, cd_a, busy_a, done_a, err_a;
  logic [15:0] bc_a;
  logic        wr_b, ce_b, cd_b, busy_b, done_b, err_b;
  logic [15:0] bc_b;

  cfg_chain_loader #(.CHAIN_LEN(48), .WORD_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start_a), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(wr_a),
    .config_en(ce_a), .config_data_out(cd_a), .busy(busy_a), .done(done_a),
    .error(err_a), .bit_count(bc_a)
  );

  cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .clk(clk), .nrst(nrst), .en(en), .start(start_b), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(wr_b),
    .config_en(ce_b), .config_data_out(cd_b), .busy(busy_b), .done(done_b),
    .error(err_b), .bit_count(bc_b)
  );

  logic        sel;
  logic        m_wr, m_ce, m_cd, m_busy, m_done, m_err;
  logic [15:0] m_bc;
  assign m_wr   = sel ? wr_b   : wr_a;
  assign m_ce   = sel ? ce_b   : ce_a;
  assign m_cd   = sel ? cd_b   : cd_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_bc   = sel ? bc_b   : bc_a;

  int checks   = 0;
  int failures = 0;

  logic [7:0] g_words[$];
  bit         g_bits[$];
  bit         g_cap[$];
  bit         g_ref_cap[$];

  typedef struct {
    bit          short12;
    logic [47:0] words;
    logic [7:0]  crc_xor;
    int          stall;
    bit          exp_err;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // CRC-8 (0x07, init 0) over the model bit list, in shift order
  function automatic logic [7:0] crc_model();
    logic [7:0] c;
    c = 8'h00;
    foreach (g_bits[i]) begin
      c = c ^ {g_bits[i], 7'b0};
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Expand data words MSB-first, keep the first len bits, append CRC trailer word
  task automatic prep(input int len, input logic [7:0] xr);
    g_bits.delete();
    foreach (g_words[i])
      for (int b = 7; b >= 0; b--) g_bits.push_back(g_words[i][b]);
    while (g_bits.size() > len) void'(g_bits.pop_back());
    g_words.push_back(crc_model() ^ xr);
  endtask

  // stall: 0 none, 1 directed en gap + valid gap, 2 random stalls and stray starts
  task automatic run_load(input bit s, input int len, input int stall, input bit exp_err, input string nm);
    int runs[$];
    int exp_runs[$];
    int cur_run, idx, exp_bc, cyc, en_gap, vdrop, rem, mism;
    int bad_bc, bad_en, bad_dout, bad_busy;
    bit fin, en_gap_done, vdrop_done;
    cur_run = 0; idx = 0; exp_bc = 0; cyc = 0; en_gap = 0; vdrop = 0;
    bad_bc = 0; bad_en = 0; bad_dout = 0; bad_busy = 0;
    fin = 1'b0; en_gap_done = 1'b0; vdrop_done = 1'b0;
    g_cap.delete();
    sel = s;
    @(negedge clk);
    en = 1'b1; abort = 1'b0; word_valid = 1'b0;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    while (!fin && cyc < 3000) begin
      start_a = 1'b0; start_b = 1'b0;
      en = 1'b1;
      if (stall == 1 && en_gap > 0) begin
        en = 1'b0;
        en_gap--;
        if (en_gap == 0) en_gap_done = 1'b1;
      end
      if (stall == 2 && $urandom_range(7) == 0) en = 1'b0;
      word_valid = (idx < g_words.size());
      if (stall == 1 && idx == 3 && !vdrop_done) word_valid = 1'b0;
      if (stall == 2 && $urandom_range(3) == 0) word_valid = 1'b0;
      word_in = (idx < g_words.size()) ? g_words[idx] : 8'($urandom);
      if (stall == 2 && $urandom_range(15) == 0) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      #1;
      if (m_bc != 16'(exp_bc)) bad_bc++;
      if (m_ce && !en) bad_en++;
      if (m_cd && !m_ce) bad_dout++;
      if (!m_done && !m_busy) bad_busy++;
      if (m_done) fin = 1'b1;
      if (m_ce) begin
        g_cap.push_back(m_cd);
        exp_bc++;
        cur_run++;
      end else if (cur_run > 0) begin
        runs.push_back(cur_run);
        cur_run = 0;
      end
      if (stall == 1 && idx == 3 && !vdrop_done && m_wr && !word_valid) begin
        vdrop++;
        if (vdrop == 3) vdrop_done = 1'b1;
      end
      if (en && word_valid && m_wr) idx++;
      if (stall == 1 && !en_gap_done && en_gap == 0 && m_ce && m_bc == 16'd10) en_gap = 5;
      cyc++;
      if (!fin) @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0; word_valid = 1'b0;
    check({nm, "_done_seen"}, int'(fin), 1);
    check({nm, "_done"}, int'(m_done), 1);
    check({nm, "_error"}, int'(m_err), int'(exp_err));
    check({nm, "_busy"}, int'(m_busy), 0);
    check({nm, "_bit_count"}, int'(m_bc), len);
    check({nm, "_cfg_cycles"}, g_cap.size(), len);
    mism = 0;
    foreach (g_cap[i]) if (i < g_bits.size() && g_cap[i] != g_bits[i]) mism++;
    check({nm, "_bit_mismatches"}, mism, 0);
    check({nm, "_words_taken"}, idx, g_words.size());
    check({nm, "_bc_track_errs"}, bad_bc, 0);
    check({nm, "_cfg_en_while_en_low"}, bad_en, 0);
    check({nm, "_dout_without_cfg_en"}, bad_dout, 0);
    check({nm, "_busy_gaps"}, bad_busy, 0);
    if (stall == 0) begin
      rem = len;
      while (rem > 0) begin
        exp_runs.push_back(rem > 8 ? 8 : rem);
        rem -= 8;
      end
      mism = (runs.size() == exp_runs.size()) ? 0 : 1;
      foreach (runs[i]) if (i < exp_runs.size() && runs[i] != exp_runs[i]) mism++;
      check({nm, "_run_lengths"}, mism, 0);
    end
    if (stall == 1) check({nm, "_en_gap_applied"}, int'(en_gap_done && vdrop_done), 1);
  endtask

  // Start a 48-bit load and feed words until bit_count==target is seen in SHIFT
  task automatic feed_until(input int target, output bit ok);
    int idx, cyc;
    idx = 0; cyc = 0; ok = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    en = 1'b1; abort = 1'b0; word_valid = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (!ok && cyc < 500) begin
      word_valid = (idx < g_words.size());
      word_in = (idx < g_words.size()) ? g_words[idx] : 8'h00;
      #1;
      if (m_wr && word_valid) idx++;
      if (m_ce && m_bc == 16'(target)) ok = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    int  nz, bad, packed12, ones;
    bit  ok;
    logic [7:0] xr;
    int  len;
    bit  s;

    tbl[0] = '{1'b0, 48'h00_00_00_00_00_00, 8'h00, 0, 1'b0};
    tbl[1] = '{1'b0, 48'h80_00_00_00_00_00, 8'h00, 0, 1'b0};
    tbl[2] = '{1'b0, 48'h80_00_00_00_00_00, 8'h01, 0, 1'b1};
    tbl[3] = '{1'b1, 48'hA5_F0_00_00_00_00, 8'h00, 0, 1'b0};
    tbl[4] = '{1'b0, 48'h3C_5A_C3_96_0F_E1, 8'h00, 1, 1'b0};
    tbl[5] = '{1'b0, 48'h3C_5A_C3_96_0F_E1, 8'h00, 0, 1'b0};

    nrst = 1'b0; en = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    word_valid = 1'b0; word_in = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nz = int'(wr_a) + int'(ce_a) + int'(cd_a) + int'(busy_a) + int'(done_a) + int'(err_a) + int'(bc_a != 16'd0)
       + int'(wr_b) + int'(ce_b) + int'(cd_b) + int'(busy_b) + int'(done_b) + int'(err_b) + int'(bc_b != 16'd0);
    check("reset_outputs_nonzero", nz, 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      len = tbl[i].short12 ? 12 : 48;
      g_words.delete();
      for (int k = 0; k < (len + 7) / 8; k++) g_words.push_back(tbl[i].words[47 - 8*k -: 8]);
      prep(len, tbl[i].crc_xor);
      run_load(tbl[i].short12, len, tbl[i].stall, tbl[i].exp_err, $sformatf("vec%0d", i));
      if (i == 0) begin
        ones = 0;
        foreach (g_cap[j]) ones += int'(g_cap[j]);
        check("vec0_dout_ones", ones, 0);
      end
      if (i == 1) check("vec1_first_bit", (g_cap.size() > 0) ? int'(g_cap[0]) : -1, 1);
      if (i == 3) begin
        packed12 = 0;
        foreach (g_cap[j]) packed12 = (packed12 << 1) | int'(g_cap[j]);
        check("vec3_serial_12bits", packed12, 'hA5F);
      end
      if (i == 4) g_ref_cap = g_cap;
      if (i == 5) begin
        bad = (g_ref_cap.size() == g_cap.size()) ? 0 : 1;
        foreach (g_cap[j]) if (j < g_ref_cap.size() && g_cap[j] != g_ref_cap[j]) bad++;
        check("stall_vs_nostall_order", bad, 0);
      end
    end

    for (int r = 0; r < 8; r++) begin
      s   = ($urandom_range(2) == 0);
      len = s ? 12 : 48;
      g_words.delete();
      for (int k = 0; k < (len + 7) / 8; k++) g_words.push_back(8'($urandom));
      xr = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      prep(len, xr);
      run_load(s, len, 2, xr != 8'h00, $sformatf("rand%0d", r));
    end

    g_words.delete();
    for (int k = 0; k < 6; k++) g_words.push_back(8'($urandom));
    prep(48, 8'h00);
    feed_until(19, ok);
    check("abort_reach_bc19", int'(ok), 1);
    @(negedge clk);
    abort = 1'b1; word_valid = 1'b1; word_in = 8'h5A;
    #1;
    check("abort_cfg_en_same_cycle", int'(m_ce), 0);
    check("abort_dout_same_cycle", int'(m_cd), 0);
    check("abort_no_ready", int'(m_wr), 0);
    check("abort_bit_count", int'(m_bc), 20);
    @(negedge clk);
    abort = 1'b0; word_valid = 1'b0;
    #1;
    check("abort_done", int'(m_done), 1);
    check("abort_error", int'(m_err), 1);
    check("abort_busy", int'(m_busy), 0);
    run_load(1'b0, 48, 0, 1'b0, "after_abort");

    g_words.delete();
    for (int k = 0; k < 6; k++) g_words.push_back(8'($urandom));
    prep(48, 8'h00);
    feed_until(29, ok);
    check("reset_reach_bc29", int'(ok), 1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    nz = int'(wr_a) + int'(ce_a) + int'(cd_a) + int'(busy_a) + int'(done_a) + int'(err_a) + int'(bc_a != 16'd0);
    check("midload_reset_outputs_nonzero", nz, 0);
    @(negedge clk);
    nrst = 1'b1; en = 1'b1; word_valid = 1'b1; word_in = 8'hFF;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (wr_a || busy_a || ce_a) bad++;
      @(negedge clk);
    end
    word_valid = 1'b0;
    check("no_ready_without_start", bad, 0);
    run_load(1'b0, 48, 0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
